calc_entrada_multidigito: RTL and testbench
===========================================

# calc_entrada_multidigito

Keypad-entry sequencer for the digital calculator: the parametrised successor of the single-digit operand/operator entry FSM. It accepts multi-digit decimal operands A and B, an operator, and '=', then presents them to the ALU/register-bank path. It adds clear, operator replacement, digit-count limiting and result chaining.

## Interface
- `W`, 8: operand width in bits. The width must hold 10^DIGITS − 1.
- `DIGITS`, 2: maximum decimal digits per operand.
- `clk`  in  1: sole clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `ready`  in  1: keypad key-valid level. It is high while a key is held.
- `teclas`  in  8: key code, valid while `ready` is high. Codes: 0–9 digit, 10 '+', 11 '−', 12 '×', 13 '÷', 14 '=', 15 'C'. All other codes are ignored.
- `resultado`  in  W: current ALU result, used only for chaining.
- `saidaA`  out  W: operand A, binary.
- `saidaB`  out  W: operand B, binary.
- `op`  out  2: operator, 0 add, 1 sub, 2 mul, 3 div.
- `sinal`  out  1: 1 when `op` is sub. Kept for the existing ALU.
- `igual`  out  1: high while in SHOW. Result is valid.

## Operation
- **Key event:** `ready` is high and the registered `ready_q` is low. `teclas` is sampled in that same cycle.
  - At most one event per press, regardless of hold length.
  - Non-event cycles change nothing except `ready_q`.
- **States:** ENTER_A, ENTER_B, SHOW. Internal digit counter `nd`, 0..DIGITS.
- **ENTER_A:**
  - Digit d with `nd` < DIGITS: `saidaA` ← `saidaA`·10 + d, truncated to W bits; `nd`++.
  - Digit with `nd` = DIGITS: ignored.
  - Operator: latch `op`; `nd` ← 0; `saidaB` ← 0; go to ENTER_B. This is accepted even with `nd` = 0, so A = 0.
  - '=': ignored.
- **ENTER_B:**
  - Digit: same accumulation rule, applied to `saidaB`.
  - Operator with `nd` = 0: replaces `op`; stay in ENTER_B.
  - Operator with `nd` > 0: ignored.
  - '=' with `nd` > 0: go to SHOW.
  - '=' with `nd` = 0: ignored.
- **SHOW:**
  - Digit d: `saidaA` ← d; `saidaB` ← 0; `nd` ← 1; go to ENTER_A.
  - Operator: chaining. `saidaA` ← `resultado`; latch `op`; `saidaB` ← 0; `nd` ← 0; go to ENTER_B.
  - '=': ignored.
- **'C' in any state:** `saidaA`, `saidaB`, `op`, `nd` ← 0; go to ENTER_A.
- **Derived outputs:** `sinal` = (`op` == 1). `igual` = (state == SHOW). Both are registered or decoded from registers, never from inputs.
- **Unused state encodings:** go to ENTER_A with all registers cleared.

## Timing
- **Reset:** state ENTER_A; `saidaA` = 0, `saidaB` = 0, `op` = 0, `sinal` = 0, `igual` = 0, `nd` = 0, `ready_q` = 0.
  - If `ready` is high on the first cycle after reset, that is an event.
- **Latency:** every output update is visible one clock after the event cycle.
- **Reset mid-entry:** discards all partial operands on that edge. Reset has priority over a coincident event.
- **`resultado`:** sampled only in the event cycle of an operator key in SHOW. The source must hold it stable for that cycle.
- **Back-to-back events:** need at least one cycle of `ready` low between presses. There is no other throughput limit.

## Configuration
- **`CALC_MULDIV_EN` defined:** codes 12 and 13 are operators mapping to `op` 2 and 3.
- **`CALC_MULDIV_EN` undefined:** codes 12 and 13 are ignored in every state, like unused codes. `op` only ever takes 0 or 1.

## Test plan
- **Basic sequence, W=8, DIGITS=2:** keys 4, 2, '+', 7, '=' → `saidaA` = 42, `saidaB` = 7, `op` = 0, `sinal` = 0, `igual` = 1 one cycle after '='.
- **Digit limit and hold:**
  - Keys 9, 9, 9 → `saidaA` = 99.
  - Holding `ready` high for 10 cycles on key 5 in ENTER_B yields one digit only.
- **Operator replace and '=' guard:** keys 3, '+', '−', '=' → '=' ignored, `igual` = 0, `op` = 1, `sinal` = 1. Then 2, '=' → `saidaB` = 2, `igual` = 1.
- **Chaining and restart:**
  - In SHOW with `resultado` = 35, key '−' → `saidaA` = 35, `saidaB` = 0, state ENTER_B.
  - Separately, in SHOW key 6 → `saidaA` = 6, `igual` = 0.
- **Clear and reset:**
  - 'C' during ENTER_B after 1, '+', 8 → all outputs 0, ENTER_A.
  - Reset asserted in the same cycle as a digit event → outputs 0, digit discarded.
- **Macro, undefined:** keys 4, 12, 5 → 12 ignored, `saidaA` = 45.
- **Macro, defined:** keys 4, 12, 5, '=' → `op` = 2, `saidaA` = 4, `saidaB` = 5.

Source files
------------

// File: rtl/calc_entrada_multidigito.sv
// Multi-digit keypad entry sequencer for the calculator: builds decimal operands A and B,
// latches the operator and signals '='. Optional mul/div operator keys: CALC_MULDIV_EN.
module calc_entrada_multidigito #(
    parameter int W      = 8,
    parameter int DIGITS = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ready,
    input  logic [7:0]   teclas,
    input  logic [W-1:0] resultado,
    output logic [W-1:0] saidaA,
    output logic [W-1:0] saidaB,
    output logic [1:0]   op,
    output logic         sinal,
    output logic         igual
);

    localparam int NDW = $clog2(DIGITS + 1);
    localparam logic [NDW-1:0] ND_MAX = NDW'(DIGITS);

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        SHOW    = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   saida_a_q, saida_a_d;
    logic [W-1:0]   saida_b_q, saida_b_d;
    logic [1:0]     op_q, op_d;
    logic [NDW-1:0] nd_q, nd_d;
    logic           ready_q, ready_d;

    logic           key_event;
    logic           is_digit, is_op, is_eq, is_clr, digit_ok;
    logic [3:0]     digit;
    logic [1:0]     op_key;

    // x*10 + d, truncated to W bits
    function automatic logic [W-1:0] mac10(input logic [W-1:0] x, input logic [3:0] d);
        logic [W+3:0] wide;
        wide = ({4'b0000, x} << 3) + ({4'b0000, x} << 1) + {{W{1'b0}}, d};
        return wide[W-1:0];
    endfunction

    always_comb begin
        key_event = ready & ~ready_q;
        is_digit  = (teclas < 8'd10);
        digit     = teclas[3:0];
`ifdef CALC_MULDIV_EN
        is_op     = (teclas >= 8'd10) && (teclas <= 8'd13);
`else
        is_op     = (teclas == 8'd10) || (teclas == 8'd11);
`endif
        op_key    = 2'(teclas - 8'd10);
        is_eq     = (teclas == 8'd14);
        is_clr    = (teclas == 8'd15);
        digit_ok  = (nd_q < ND_MAX);
    end

    always_comb begin
        state_d   = state_q;
        saida_a_d = saida_a_q;
        saida_b_d = saida_b_q;
        op_d      = op_q;
        nd_d      = nd_q;
        ready_d   = ready;

        case (state_q)
            ENTER_A: begin
                if (key_event) begin
                    if (is_clr) begin
                        saida_a_d = '0;
                        saida_b_d = '0;
                        op_d      = '0;
                        nd_d      = '0;
                    end else if (is_digit && digit_ok) begin
                        saida_a_d = mac10(saida_a_q, digit);
                        nd_d      = nd_q + NDW'(1);
                    end else if (is_op) begin
                        op_d      = op_key;
                        nd_d      = '0;
                        saida_b_d = '0;
                        state_d   = ENTER_B;
                    end
                end
            end
            ENTER_B: begin
                if (key_event) begin
                    if (is_clr) begin
                        saida_a_d = '0;
                        saida_b_d = '0;
                        op_d      = '0;
                        nd_d      = '0;
                        state_d   = ENTER_A;
                    end else if (is_digit && digit_ok) begin
                        saida_b_d = mac10(saida_b_q, digit);
                        nd_d      = nd_q + NDW'(1);
                    end else if (is_op && nd_q == '0) begin
                        op_d = op_key;
                    end else if (is_eq && nd_q != '0) begin
                        state_d = SHOW;
                    end
                end
            end
            SHOW: begin
                if (key_event) begin
                    if (is_clr) begin
                        saida_a_d = '0;
                        saida_b_d = '0;
                        op_d      = '0;
                        nd_d      = '0;
                        state_d   = ENTER_A;
                    end else if (is_digit) begin
                        saida_a_d = {{(W-4){1'b0}}, digit};
                        saida_b_d = '0;
                        nd_d      = NDW'(1);
                        state_d   = ENTER_A;
                    end else if (is_op) begin
                        // chaining: previous result becomes the new A
                        saida_a_d = resultado;
                        op_d      = op_key;
                        saida_b_d = '0;
                        nd_d      = '0;
                        state_d   = ENTER_B;
                    end
                end
            end
            default: begin
                saida_a_d = '0;
                saida_b_d = '0;
                op_d      = '0;
                nd_d      = '0;
                state_d   = ENTER_A;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ENTER_A;
            saida_a_q <= '0;
            saida_b_q <= '0;
            op_q      <= '0;
            nd_q      <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            saida_a_q <= saida_a_d;
            saida_b_q <= saida_b_d;
            op_q      <= op_d;
            nd_q      <= nd_d;
            ready_q   <= ready_d;
        end
    end

    assign saidaA = saida_a_q;
    assign saidaB = saida_b_q;
    assign op     = op_q;
    assign sinal  = (op_q == 2'd1);
    assign igual  = (state_q == SHOW);

endmodule

// File: tb/tb_calc_entrada_multidigito.sv
// Scoreboard bench for calc_entrada_multidigito: directed key sequences push expected
// outputs with a due cycle; a monitor compares them when due.
module tb_calc_entrada_multidigito;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         ready;
    logic [7:0]   teclas;
    logic [W-1:0] resultado;
    logic [W-1:0] saidaA, saidaB;
    logic [1:0]   op;
    logic         sinal, igual;

    calc_entrada_multidigito #(.W(W), .DIGITS(2)) dut (
        .clk(clk), .reset(reset), .ready(ready), .teclas(teclas), .resultado(resultado),
        .saidaA(saidaA), .saidaB(saidaB), .op(op), .sinal(sinal), .igual(igual)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           due;
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   o;
        logic         s;
        logic         g;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // monitor: compares every expectation that falls due on this falling edge
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (e.due != cyc || saidaA !== e.a || saidaB !== e.b || op !== e.o ||
                sinal !== e.s || igual !== e.g) begin
                errors++;
                $display("FAIL %s: got A=%0d B=%0d op=%0d sinal=%0b igual=%0b, want A=%0d B=%0d op=%0d sinal=%0b igual=%0b",
                         e.name, saidaA, saidaB, op, sinal, igual, e.a, e.b, e.o, e.s, e.g);
            end else begin
                $display("ok   %s: A=%0d B=%0d op=%0d sinal=%0b igual=%0b",
                         e.name, saidaA, saidaB, op, sinal, igual);
            end
        end
    end

    task automatic expect_at(input int due, input string name, input int a, input int b,
                             input int o, input int g);
        exp_t e;
        e.due  = due;
        e.name = name;
        e.a    = W'(a);
        e.b    = W'(b);
        e.o    = 2'(o);
        e.s    = (o == 1);
        e.g    = g[0];
        sb.push_back(e);
    endtask

    // one key press held for 'hold' cycles, then released for one cycle
    task automatic press(input string name, input int key, input int hold,
                         input int a, input int b, input int o, input int g);
        @(negedge clk);
        ready  = 1'b1;
        teclas = 8'(key);
        expect_at(cyc + 1, name, a, b, o, g);
        if (hold > 1) expect_at(cyc + hold, {name, "_held"}, a, b, o, g);
        repeat (hold) @(negedge clk);
        ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic key(input string name, input int k, input int a, input int b,
                       input int o, input int g);
        press(name, k, 1, a, b, o, g);
    endtask

    initial begin
        reset     = 1'b1;
        ready     = 1'b0;
        teclas    = 8'd0;
        resultado = 8'd0;
        @(negedge clk);
        expect_at(cyc + 1, "reset_state", 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // basic 42 + 7 =
        key("basic_4", 4, 4, 0, 0, 0);
        key("basic_2", 2, 42, 0, 0, 0);
        key("basic_add", 10, 42, 0, 0, 0);
        key("basic_7", 7, 42, 7, 0, 0);
        key("basic_eq", 14, 42, 7, 0, 1);

        // chaining from SHOW, then restart with a digit
        resultado = 8'd35;
        key("chain_sub", 11, 35, 0, 1, 0);
        key("chain_6", 6, 35, 6, 1, 0);
        key("chain_eq", 14, 35, 6, 1, 1);
        key("restart_6", 6, 6, 0, 1, 0);
        key("restart_9", 9, 69, 0, 1, 0);
        key("restart_limit", 9, 69, 0, 1, 0);

        // digit limit
        key("clr_a", 15, 0, 0, 0, 0);
        key("lim_9a", 9, 9, 0, 0, 0);
        key("lim_9b", 9, 99, 0, 0, 0);
        key("lim_9c", 9, 99, 0, 0, 0);
        key("eq_in_enter_a", 14, 99, 0, 0, 0);

        // operator replace and '=' guard
        key("clr_b", 15, 0, 0, 0, 0);
        key("rep_3", 3, 3, 0, 0, 0);
        key("rep_add", 10, 3, 0, 0, 0);
        key("rep_sub", 11, 3, 0, 1, 0);
        key("rep_eq_guard", 14, 3, 0, 1, 0);
        key("rep_2", 2, 3, 2, 1, 0);
        key("rep_eq", 14, 3, 2, 1, 1);
        key("show_eq_ignored", 14, 3, 2, 1, 1);

        // clear mid ENTER_B, then operator with no digits
        key("clr_c", 15, 0, 0, 0, 0);
        key("clr_1", 1, 1, 0, 0, 0);
        key("clr_add", 10, 1, 0, 0, 0);
        key("clr_8", 8, 1, 8, 0, 0);
        key("clr_in_b", 15, 0, 0, 0, 0);
        key("op_nd0", 10, 0, 0, 0, 0);
        key("op_nd0_5", 5, 0, 5, 0, 0);

        // held key gives one digit only
        key("clr_d", 15, 0, 0, 0, 0);
        key("hold_1", 1, 1, 0, 0, 0);
        key("hold_add", 10, 1, 0, 0, 0);
        press("hold_5", 5, 10, 1, 5, 0, 0);
        key("hold_3", 3, 1, 53, 0, 0);
        key("hold_4_limit", 4, 1, 53, 0, 0);
        key("op_after_digit", 11, 1, 53, 0, 0);
        key("hold_eq", 14, 1, 53, 0, 1);
        key("unused_code", 20, 1, 53, 0, 1);

        // reset coincident with a digit event
        @(negedge clk);
        reset  = 1'b1;
        ready  = 1'b1;
        teclas = 8'd7;
        expect_at(cyc + 1, "reset_with_digit", 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        ready = 1'b0;
        @(negedge clk);
        key("after_reset_3", 3, 3, 0, 0, 0);

        // mul/div codes
        key("clr_e", 15, 0, 0, 0, 0);
        key("md_4", 4, 4, 0, 0, 0);
`ifdef CALC_MULDIV_EN
        key("md_mul", 12, 4, 0, 2, 0);
        key("md_5", 5, 4, 5, 2, 0);
        key("md_eq", 14, 4, 5, 2, 1);
        key("md_div_chain", 13, 35, 0, 3, 0);
`else
        key("md_mul_ignored", 12, 4, 0, 0, 0);
        key("md_5", 5, 45, 0, 0, 0);
        key("md_eq_ignored", 14, 45, 0, 0, 0);
        key("md_div_ignored", 13, 45, 0, 0, 0);
`endif

        repeat (20) begin
            if (sb.size() > 0) @(negedge clk);
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
